// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program-counter stage of the simple processor. Holds the 32-bit fetch
//   address, produces PC+4 and the branch/jump target for the external
//   PC-select mux, and loads the mux result (NEXT_PC) back into the PC.
//   The PC is frozen while instruction memory signals BUSYWAIT.
//
// Ports
//   CLK            in   1          clock, rising edge
//   RESET          in   1          asynchronous reset, active-low
//   NEXT_PC        in   32         selected next PC from the PC-select mux
//   OFFSET         in   8          signed branch/jump offset, in words
//   BUSYWAIT       in   1          instruction memory busy; 1 = hold PC
//   PC             out  32         current fetch address
//   PC_PLUS4       out  32         PC + 4 (combinational)
//   BRANCH_TARGET  out  32         PC + 4 + sign-extended (OFFSET << 2)
//   FETCH_VALID    out  1          PC is a valid fetch request
//   STALLED        out  1          unit is holding the PC for BUSYWAIT
//   REDIRECT       out  1          1-cycle pulse after a non-sequential update
//   UPDATE_COUNT   out  CNT_WIDTH  saturating count of PC updates since reset
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          NEXT_PC,
    input  logic [7:0]           OFFSET,
    input  logic                 BUSYWAIT,
    output logic [31:0]          PC,
    output logic [31:0]          PC_PLUS4,
    output logic [31:0]          BRANCH_TARGET,
    output logic                 FETCH_VALID,
    output logic                 STALLED,
    output logic                 REDIRECT,
    output logic [CNT_WIDTH-1:0] UPDATE_COUNT
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t               state_q;
    logic [31:0]          pc_q;
    logic                 fetch_valid_q;
    logic                 stalled_q;
    logic                 redirect_q;
    logic [CNT_WIDTH-1:0] update_count_q;

    logic [31:0]          pc_plus4;
    logic [31:0]          offset_bytes;
    logic                 non_seq;
    logic [CNT_WIDTH-1:0] update_count_d;

    // Address arithmetic wraps modulo 2^32 on purpose; no carry-out is kept.
    assign pc_plus4      = pc_q + 32'd4;
    assign offset_bytes  = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    assign non_seq       = (NEXT_PC != pc_plus4);

    // Counter holds at all-ones instead of wrapping back to zero.
    assign update_count_d = (&update_count_q) ? update_count_q
                                              : update_count_q + 1'b1;

    // NOTE: every register below is assigned with <= so all of them sample the
    // same pre-edge values; blocking assignments here would let later lines
    // see values already updated in this same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= ST_INIT;
            pc_q           <= RESET_VECTOR;
            fetch_valid_q  <= 1'b0;
            stalled_q      <= 1'b0;
            redirect_q     <= 1'b0;
            update_count_q <= '0;
        end else begin
            // Pulse outputs default low; only an actual update raises REDIRECT.
            redirect_q <= 1'b0;
            unique case (state_q)
                ST_INIT: begin
                    // PC stays at RESET_VECTOR so that address is fetched first.
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                    stalled_q     <= 1'b0;
                end
                ST_RUN, ST_STALL: begin
                    fetch_valid_q <= 1'b1;
                    // BUSYWAIT sampled at this edge wins over the update.
                    if (BUSYWAIT) begin
                        state_q   <= ST_STALL;
                        stalled_q <= 1'b1;
                    end else begin
                        state_q        <= ST_RUN;
                        stalled_q      <= 1'b0;
                        pc_q           <= NEXT_PC;
                        update_count_q <= update_count_d;
                        redirect_q     <= non_seq;
                    end
                end
                default: begin
                    state_q       <= ST_INIT;
                    fetch_valid_q <= 1'b0;
                    stalled_q     <= 1'b0;
                end
            endcase
        end
    end

    assign PC            = pc_q;
    assign PC_PLUS4      = pc_plus4;
    assign BRANCH_TARGET = pc_plus4 + offset_bytes;
    assign FETCH_VALID   = fetch_valid_q;
    assign STALLED       = stalled_q;
    assign REDIRECT      = redirect_q;
    assign UPDATE_COUNT  = update_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//   Directed bench for pc_unit. dut drives the default configuration with a
//   selectable NEXT_PC (sequential or hand-picked). dut_w uses
//   RESET_VECTOR=FFFF_FFFC and a 4-bit counter, always runs sequentially, and
//   shares clock and reset with dut.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic        CLK;
    logic        RESET;
    logic [7:0]  offset;
    logic        busywait;
    logic        tie_seq;
    logic [31:0] manual_pc;
    logic [31:0] next_pc;

    logic [31:0] pc, pc_plus4, branch_target;
    logic        fetch_valid, stalled, redirect;
    logic [31:0] update_count;

    logic [31:0] w_pc, w_pc_plus4, w_branch_target;
    logic        w_fetch_valid, w_stalled, w_redirect;
    logic [3:0]  w_update_count;

    int vectors;
    int miscompares;

    assign next_pc = tie_seq ? pc_plus4 : manual_pc;

    pc_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .NEXT_PC       (next_pc),
        .OFFSET        (offset),
        .BUSYWAIT      (busywait),
        .PC            (pc),
        .PC_PLUS4      (pc_plus4),
        .BRANCH_TARGET (branch_target),
        .FETCH_VALID   (fetch_valid),
        .STALLED       (stalled),
        .REDIRECT      (redirect),
        .UPDATE_COUNT  (update_count)
    );

    pc_unit #(
        .RESET_VECTOR (32'hFFFF_FFFC),
        .CNT_WIDTH    (4)
    ) dut_w (
        .CLK           (CLK),
        .RESET         (RESET),
        .NEXT_PC       (w_pc_plus4),
        .OFFSET        (8'h7F),
        .BUSYWAIT      (1'b0),
        .PC            (w_pc),
        .PC_PLUS4      (w_pc_plus4),
        .BRANCH_TARGET (w_branch_target),
        .FETCH_VALID   (w_fetch_valid),
        .STALLED       (w_stalled),
        .REDIRECT      (w_redirect),
        .UPDATE_COUNT  (w_update_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b0;
        offset      = 8'h00;
        busywait    = 1'b0;
        tie_seq     = 1'b1;
        manual_pc   = 32'h0;

        // ---- reset held for two edges ----
        tick();
        tick();
        check("rst_pc",       pc,           32'h0);
        check("rst_pc4",      pc_plus4,     32'h4);
        check("rst_fv",       fetch_valid,  0);
        check("rst_stall",    stalled,      0);
        check("rst_redir",    redirect,     0);
        check("rst_cnt",      update_count, 0);
        check("w_rst_pc",     w_pc,         32'hFFFF_FFFC);
        check("w_rst_pc4",    w_pc_plus4,   32'h0);

        // ---- release: one INIT cycle with PC unchanged ----
        RESET = 1'b1;
        check("init_fv",      fetch_valid,  0);
        tick();
        check("run_pc0",      pc,           32'h0);
        check("run_fv",       fetch_valid,  1);
        check("run_cnt0",     update_count, 0);

        // ---- five sequential updates ----
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("seq_pc%0d", i), pc, 32'(4 * i));
            check($sformatf("seq_redir%0d", i), redirect, 0);
            if (i == 1) begin
                // dut_w just made its first update across the 2^32 boundary.
                check("w_wrap_pc",  w_pc,            32'h0);
                check("w_tgt_7f",   w_branch_target, 32'h200);
                check("w_redir",    w_redirect,      0);
            end
        end
        check("seq_cnt", update_count, 5);

        // ---- backward branch: PC=20, OFFSET=-2 words -> 24-8 = 16 ----
        offset = 8'hFE;
        #1;
        check("br_tgt_fe", branch_target, 32'd16);
        offset = 8'h80;
        #1;
        check("br_tgt_80", branch_target, 32'd24 - 32'd512);
        tie_seq   = 1'b0;
        manual_pc = 32'd16;
        tick();
        check("br_pc",    pc,           32'd16);
        check("br_redir", redirect,     1);
        check("br_cnt",   update_count, 6);
        tie_seq = 1'b1;
        tick();
        check("br_pc_after",    pc,       32'd20);
        check("br_redir_pulse", redirect, 0);

        // ---- three stall edges at PC=20, NEXT_PC changes ignored ----
        busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tie_seq   = 1'b0;
            manual_pc = 32'h100 + 32'(i);
            check($sformatf("stall_pc%0d", i),  pc,           32'd20);
            check($sformatf("stall_st%0d", i),  stalled,      1);
            check($sformatf("stall_fv%0d", i),  fetch_valid,  1);
            check($sformatf("stall_rd%0d", i),  redirect,     0);
            check($sformatf("stall_cnt%0d", i), update_count, 7);
        end
        busywait = 1'b0;
        tie_seq  = 1'b1;
        tick();
        check("unstall_pc",  pc,           32'd24);
        check("unstall_st",  stalled,      0);
        check("unstall_cnt", update_count, 8);
        check("unstall_rd",  redirect,     0);

        // ---- misaligned NEXT_PC passes through untouched ----
        tie_seq   = 1'b0;
        manual_pc = 32'h0000_1003;
        tick();
        check("misal_pc",  pc,       32'h0000_1003);
        check("misal_rd",  redirect, 1);
        check("misal_pc4", pc_plus4, 32'h0000_1007);

        // ---- async reset mid-stall, between edges ----
        busywait = 1'b1;
        tick();
        check("pre_rst_st", stalled, 1);
        #2;
        RESET = 1'b0;
        #1;
        check("async_pc",  pc,           32'h0);
        check("async_st",  stalled,      0);
        check("async_fv",  fetch_valid,  0);
        check("async_cnt", update_count, 0);
        check("w_async_pc", w_pc,        32'hFFFF_FFFC);
        busywait = 1'b0;
        tie_seq  = 1'b1;
        tick();
        RESET = 1'b1;
        tick();   // INIT -> RUN, no update

        // ---- 20 sequential updates: dut_w counter saturates at 4'hF ----
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("w_cnt14", w_update_count, 4'hE);
            if (i == 15) check("w_cnt15", w_update_count, 4'hF);
        end
        check("w_cnt_sat", w_update_count, 4'hF);
        check("w_pc_20",   w_pc,           32'h0000_004C);
        check("pc_20",     pc,             32'h0000_0050);
        check("cnt_20",    update_count,   32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
